// File: rtl/sysid_rom_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_rom_reader_if
//  Description : up_* register read bus between a requester (master) and the
//                system-ID ROM reader (slave).
//  Signals     : up_rreq   - one-cycle read request strobe (master -> slave)
//                up_raddr  - word address, sampled with up_rreq
//                up_rack   - one-cycle read acknowledge (slave -> master)
//                up_rdata  - read data, valid only while up_rack = 1, else 0
//                up_rbusy  - read or checksum scan in flight
//  Revision    : 1.0 - initial release
// ============================================================================
interface sysid_rom_reader_if #(
  parameter int UP_ADDR_WIDTH = 14,
  parameter int ROM_WIDTH     = 32
);
  logic                     up_rreq;
  logic [UP_ADDR_WIDTH-1:0] up_raddr;
  logic                     up_rack;
  logic [ROM_WIDTH-1:0]     up_rdata;
  logic                     up_rbusy;

  modport master (
    output up_rreq,
    output up_raddr,
    input  up_rack,
    input  up_rdata,
    input  up_rbusy
  );

  modport slave (
    input  up_rreq,
    input  up_raddr,
    output up_rack,
    output up_rdata,
    output up_rbusy
  );
endinterface
`default_nettype wire

// File: rtl/sysid_rom_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_rom_reader
//  Description : Bridges the up_* register read bus to the synchronous read
//                port of the system-ID ROM. Each request drives rom_addr,
//                waits out the ROM read latency and returns the word with a
//                one-cycle up_rack. One extra request can be parked in a
//                pending slot while busy.
//                Optional feature (macro SYSID_ROM_CHECKSUM_EN): after reset
//                the whole ROM is scanned and an 8-bit byte checksum is
//                published on rom_checksum / rom_checksum_vld.
//  Ports       : up_clk           - single clock, shared with the ROM
//                up_rstn          - synchronous active-low reset
//                up               - read bus (sysid_rom_reader_if.slave)
//                rom_addr         - ROM address, holds between accesses
//                rom_data         - ROM read data
//                rom_checksum     - sum mod 256 of all ROM bytes
//                rom_checksum_vld - 1 once rom_checksum is final
//  Revision    : 1.0 - initial release
// ============================================================================
module sysid_rom_reader #(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 6,
  parameter int UP_ADDR_WIDTH = 14,
  parameter int ROM_LATENCY   = 1
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  sysid_rom_reader_if.slave        up,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]     rom_data,
  output logic [7:0]               rom_checksum,
  output logic                     rom_checksum_vld
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_DATA = 3'd3,
    S_SCAN = 3'd4
  } state_t;

`ifdef SYSID_ROM_CHECKSUM_EN
  localparam state_t c_reset_state = S_SCAN;
`else
  localparam state_t c_reset_state = S_IDLE;
`endif

  // WAIT exits on the ROM_LATENCY-th edge spent in it
  localparam logic [1:0] c_lat_last = 2'(ROM_LATENCY - 1);

  state_t                   r_state;
  logic [ROM_ADDR_BITS-1:0] r_cur_addr;
  logic                     r_cur_oor;
  logic                     r_pend_vld;
  logic [ROM_ADDR_BITS-1:0] r_pend_addr;
  logic                     r_pend_oor;
  logic [1:0]               r_lat_cnt;
  logic                     r_rack;
  logic [ROM_WIDTH-1:0]     r_rdata;
  logic [ROM_ADDR_BITS-1:0] r_rom_addr;

  logic w_in_oor;
  logic w_consume;
  logic w_to_slot;

  // Address bits above the ROM range mark the request as out of range
  generate
    if (UP_ADDR_WIDTH > ROM_ADDR_BITS) begin : g_oor_chk
      assign w_in_oor = |up.up_raddr[UP_ADDR_WIDTH-1:ROM_ADDR_BITS];
    end else begin : g_oor_none
      assign w_in_oor = 1'b0;
    end
  endgenerate

  // The slot empties in IDLE and DATA when it is full; a request seen on the
  // same edge may refill it. A request arriving while it stays full is lost.
  assign w_consume = r_pend_vld && ((r_state == S_IDLE) || (r_state == S_DATA));
  assign w_to_slot = up.up_rreq
                  && !((r_state == S_IDLE) && !r_pend_vld)
                  && (!r_pend_vld || w_consume);

`ifdef SYSID_ROM_CHECKSUM_EN
  logic [ROM_ADDR_BITS:0]   r_scan_cnt;
  logic                     r_scan_iss;
  logic [ROM_LATENCY-1:0]   r_vld_dl;
  logic [ROM_ADDR_BITS-1:0] r_sum_cnt;
  logic                     r_sum_done;
  logic [7:0]               r_csum;
  logic                     r_csum_vld;
  logic [7:0]               w_word_sum;

  always_comb begin
    w_word_sum = 8'd0;
    for (int i = 0; i < ROM_WIDTH / 8; i++) begin
      w_word_sum = w_word_sum + rom_data[i*8 +: 8];
    end
  end

  assign rom_checksum     = r_csum;
  assign rom_checksum_vld = r_csum_vld;
`else
  assign rom_checksum     = 8'd0;
  assign rom_checksum_vld = 1'b0;
`endif

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      r_state     <= c_reset_state;
      r_cur_addr  <= '0;
      r_cur_oor   <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_oor  <= 1'b0;
      r_lat_cnt   <= 2'd0;
      r_rack      <= 1'b0;
      r_rdata     <= '0;
      r_rom_addr  <= '0;
`ifdef SYSID_ROM_CHECKSUM_EN
      r_scan_cnt  <= '0;
      r_scan_iss  <= 1'b0;
      r_vld_dl    <= '0;
      r_sum_cnt   <= '0;
      r_sum_done  <= 1'b0;
      r_csum      <= 8'd0;
      r_csum_vld  <= 1'b0;
`endif
    end else begin
      r_rack  <= 1'b0;
      r_rdata <= '0;

      if (w_to_slot) begin
        r_pend_vld  <= 1'b1;
        r_pend_addr <= up.up_raddr[ROM_ADDR_BITS-1:0];
        r_pend_oor  <= w_in_oor;
      end else if (w_consume) begin
        r_pend_vld  <= 1'b0;
      end

`ifdef SYSID_ROM_CHECKSUM_EN
      // r_scan_iss marks an address on rom_addr; the delay line lines it up
      // with the matching rom_data word.
      r_scan_iss  <= 1'b0;
      r_vld_dl[0] <= r_scan_iss;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_vld_dl[i] <= r_vld_dl[i-1];
      end
      if (r_vld_dl[ROM_LATENCY-1]) begin
        r_csum    <= r_csum + w_word_sum;
        r_sum_cnt <= r_sum_cnt + 1'b1;
        if (&r_sum_cnt) begin
          r_sum_done <= 1'b1;
        end
      end
`endif

      case (r_state)
        S_IDLE: begin
          if (r_pend_vld) begin
            r_cur_addr <= r_pend_addr;
            r_cur_oor  <= r_pend_oor;
            r_state    <= S_ADDR;
          end else if (up.up_rreq) begin
            r_cur_addr <= up.up_raddr[ROM_ADDR_BITS-1:0];
            r_cur_oor  <= w_in_oor;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_rom_addr <= r_cur_addr;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat_cnt == c_lat_last) begin
            r_lat_cnt <= 2'd0;
            r_state   <= S_DATA;
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end
        S_DATA: begin
          r_rack  <= 1'b1;
          r_rdata <= r_cur_oor ? '0 : rom_data;
          if (r_pend_vld) begin
            r_cur_addr <= r_pend_addr;
            r_cur_oor  <= r_pend_oor;
            r_state    <= S_ADDR;
          end else begin
            r_state    <= S_IDLE;
          end
        end
`ifdef SYSID_ROM_CHECKSUM_EN
        S_SCAN: begin
          if (!r_scan_cnt[ROM_ADDR_BITS]) begin
            r_rom_addr <= r_scan_cnt[ROM_ADDR_BITS-1:0];
            r_scan_iss <= 1'b1;
            r_scan_cnt <= r_scan_cnt + 1'b1;
          end
          if (r_sum_done) begin
            r_csum_vld <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_addr    = r_rom_addr;
  assign up.up_rack  = r_rack;
  assign up.up_rdata = r_rdata;
  assign up.up_rbusy = (r_state != S_IDLE) || r_pend_vld;

endmodule
`default_nettype wire
